// File: rtl/tile_dma_reader.sv
// tile_dma_reader: issues single-word external-memory reads and writes each returned word
// into the selected on-chip tile RAM through a one-cycle strobe.
module tile_dma_reader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RAM_AW = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  n_words_i,
    input  logic [RAM_AW-1:0] ram_base_i,
    input  logic [2:0]        tgt_sel_i,
    output logic              request_extmem_o,
    output logic [ADDR_W-1:0] addr_extmem_o,
    input  logic              valid_extmem_i,
    input  logic [DATA_W-1:0] data_extmem_i,
    output logic [DATA_W-1:0] w_data_o,
    output logic [RAM_AW-1:0] ram_addr_dma_o,
    output logic              w_fmi_o,
    output logic              w_kex_o,
    output logic              w_kpw_o,
    output logic              w_kdw_o,
    output logic              w_fmint_o,
    output logic              busy_o,
    output logic              finish_dma_o
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d, n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [RAM_AW-1:0] rbase_q, rbase_d, raddr_q, raddr_d;
    logic [2:0]        tgt_q, tgt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        strb_q, strb_d, sel_strb;
    logic              req_q, req_d, busy_q, busy_d, fin_q, fin_d;
    // selectors 5-7 run the handshake but write nowhere
    assign sel_strb = (tgt_q < 3'd5) ? (5'd1 << tgt_q) : 5'd0;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        base_d  = base_q;
        rbase_d = rbase_q;
        tgt_d   = tgt_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        strb_d  = 5'd0;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                base_d  = base_addr_i;
                n_d     = n_words_i;
                rbase_d = ram_base_i;
                tgt_d   = tgt_sel_i;
                idx_d   = '0;
                busy_d  = 1'b1;
                if (n_words_i != '0) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = base_addr_i;
                end else begin
                    state_d = DONE;
                end
            end
            REQ: if (valid_extmem_i) begin
                wdata_d = data_extmem_i;
                raddr_d = rbase_q + RAM_AW'(idx_q);
                strb_d  = sel_strb;
                req_d   = 1'b0;
                idx_d   = idx_q + CNT_W'(1);
                state_d = DRAIN;
            end
            // wait out a responder whose valid lingers from the previous word
            DRAIN: if (!valid_extmem_i) begin
                if (idx_q == n_q) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = base_q + ADDR_W'(idx_q);
                end
            end
            DONE: begin
                fin_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            base_q  <= '0;
            rbase_q <= '0;
            tgt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
            strb_q  <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            base_q  <= base_d;
            rbase_q <= rbase_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end
    assign request_extmem_o = req_q;
    assign addr_extmem_o    = addr_q;
    assign w_data_o         = wdata_q;
    assign ram_addr_dma_o   = raddr_q;
    assign {w_fmint_o, w_kdw_o, w_kpw_o, w_kex_o, w_fmi_o} = strb_q;
    assign busy_o           = busy_q;
    assign finish_dma_o     = fin_q;
endmodule

// File: tb/tb_tile_dma_reader.sv
// tb_tile_dma_reader: directed loads against a lagging responder; expectations queued at
// issue time and compared by an independent monitor.
module tb_tile_dma_reader;
    logic        clk = 1'b0;
    logic        rst_ni, start, force_valid, resp_valid;
    logic [31:0] base, resp_data;
    logic [15:0] nw, rb;
    logic [2:0]  tgt;
    logic        req, w_fmi, w_kex, w_kpw, w_kdw, w_fmint, busy, fin;
    logic [31:0] addr, w_data;
    logic [15:0] ram_addr;
    logic        valid;
    logic [4:0]  strb;
    bit          resp_en = 0;

    typedef struct packed {
        logic [4:0]  s;
        logic [15:0] ra;
        logic [31:0] d;
    } wr_t;
    wr_t         wrq[$];
    logic [31:0] reqq[$];
    int exp_fin = 0, obs_fin = 0, wr_seen = 0, n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;
    assign valid = resp_valid | force_valid;
    assign strb  = {w_fmint, w_kdw, w_kpw, w_kex, w_fmi};

    tile_dma_reader dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .base_addr_i(base),
        .n_words_i(nw), .ram_base_i(rb), .tgt_sel_i(tgt),
        .request_extmem_o(req), .addr_extmem_o(addr),
        .valid_extmem_i(valid), .data_extmem_i(resp_data),
        .w_data_o(w_data), .ram_addr_dma_o(ram_addr),
        .w_fmi_o(w_fmi), .w_kex_o(w_kex), .w_kpw_o(w_kpw), .w_kdw_o(w_kdw),
        .w_fmint_o(w_fmint), .busy_o(busy), .finish_dma_o(fin)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // responder: mem[a]=a, 2-cycle latency, valid lingers 2 cycles past acceptance
    initial begin
        logic [31:0] a;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && rst_ni && req && !valid) begin
                a = addr;
                repeat (2) @(posedge clk);
                #1;
                resp_valid = 1'b1;
                resp_data  = a;
                repeat (3) @(posedge clk);
                #1;
                resp_valid = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        logic req_prev;
        wr_t  e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (req && !req_prev) begin
                    if (reqq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_request: got addr 0x%0h expected none", addr);
                    end else check("req_addr", addr, reqq.pop_front());
                end
                if (strb != 5'd0) begin
                    wr_seen++;
                    if (wrq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got strobes 0x%0h expected none", strb);
                    end else begin
                        e = wrq.pop_front();
                        check("wr_strobe", strb, e.s);
                        check("wr_ram_addr", ram_addr, e.ra);
                        check("wr_data", w_data, e.d);
                    end
                end
                if (fin) begin
                    obs_fin++;
                    check("finish_busy_low", busy, 0);
                end
            end
            req_prev = rst_ni && req;
        end
    end

    task automatic launch(input logic [31:0] b, input logic [15:0] n, input logic [15:0] r,
                          input logic [2:0] t, input int n_exp, input bit exp_finish);
        wr_t w;
        for (int i = 0; i < n_exp; i++) begin
            reqq.push_back(b + 32'(i));
            if (t < 3'd5) begin
                w.s  = 5'(1 << t);
                w.ra = r + 16'(i);
                w.d  = b + 32'(i);
                wrq.push_back(w);
            end
        end
        if (exp_finish) exp_fin++;
        @(negedge clk);
        base = b; nw = n; rb = r; tgt = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = 32'hDEAD_BEEF; nw = 16'h7; rb = 16'h5555; tgt = 3'd0;
    endtask

    task automatic wait_fin(input string name);
        int t = 0;
        while (obs_fin < exp_fin && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, obs_fin, exp_fin);
        repeat (3) @(negedge clk);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t, w0;
        rst_ni = 1'b0; start = 1'b1; force_valid = 1'b1;
        base = 32'h1234_5678; nw = 16'd9; rb = 16'h33; tgt = 3'd1;
        repeat (3) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", w_data, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_strobes", strb, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", fin, 0);
        start = 1'b0; force_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_req", req, 0);
        check("idle_busy", busy, 0);
        resp_en = 1;

        launch(32'h0020_0000, 16'd4, 16'h0000, 3'd0, 4, 1);
        wait_fin("fmi_finish");
        launch(32'h0060_0000, 16'd16, 16'h0010, 3'd1, 16, 1);
        wait_fin("kex_finish");

        exp_fin++;
        @(negedge clk);
        nw = 16'd0; base = 32'h0000_0400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zl_busy", busy, 1);
        check("zl_finish_early", fin, 0);
        @(negedge clk);
        check("zl_finish", fin, 1);
        wait_fin("zl_finish_count");

        launch(32'hFFFF_FFFE, 16'd3, 16'hFFFF, 3'd4, 3, 1);
        wait_fin("wrap_finish");
        w0 = wr_seen;
        launch(32'h0000_0800, 16'd2, 16'h0100, 3'd6, 2, 1);
        wait_fin("discard_finish");
        check("discard_no_strobe", wr_seen - w0, 0);

        w0 = wr_seen;
        launch(32'h0000_0100, 16'd8, 16'h0040, 3'd3, 2, 0);
        t = 0;
        while (wr_seen < w0 + 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        rst_ni = 1'b0;
        check("abort_two_words", wr_seen - w0, 2);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_finish", obs_fin, exp_fin);

        w0 = wr_seen;
        launch(32'h0000_0300, 16'd2, 16'h0008, 3'd2, 2, 1);
        repeat (2) @(negedge clk);
        base = 32'h0000_9000; nw = 16'd5; rb = 16'h0; tgt = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_fin("restart_finish");
        check("restart_strobes", wr_seen - w0, 2);
        repeat (10) @(negedge clk);
        check("finish_total", obs_fin, exp_fin);
        check("reqq_empty", reqq.size(), 0);
        check("wrq_empty", wrq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
